// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer for the EX/MEM instruction: launches one bus
// request/ack transaction, stalls the pipeline meanwhile, formats store lanes and load data.
module dmem_access_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic [1:0]  ResultSrc,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic        stall_mem,
   output logic [31:0] ReadData,
   output logic        rd_valid,
   output logic        err,
   output logic [1:0]  err_code,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]    state_q;
   logic [31:0]   addr_q;
   logic          we_q;
   logic [31:0]   wdata_q;
   logic [3:0]    wstrb_q;
   logic [2:0]    f3_q;
   logic [1:0]    off_q;
   logic [CW-1:0] cnt_q;
   logic [31:0]   rdata_q;
   logic          to_q;

   logic        op;
   logic        f3_legal;
   logic        misal;
   logic        idle_err;
   logic        launch;
   logic        busy;
   logic        resp;
   logic [31:0] st_wdata;
   logic [3:0]  st_wstrb;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;

   assign op = mem_valid & (MemWrite | (ResultSrc == 2'b01));

   always_comb begin
      f3_legal = 1'b0;
      if (MemWrite) begin
         f3_legal = funct3 inside {3'b000, 3'b001, 3'b010};
      end else begin
         f3_legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
   end

   assign misal = ((funct3[1:0] == 2'b01) & ALUResult[0]) |
                  ((funct3[1:0] == 2'b10) & (|ALUResult[1:0]));

   assign idle_err = (state_q == IDLE) & op & (~f3_legal | misal);
   assign launch   = (state_q == IDLE) & op & f3_legal & ~misal;
   assign busy     = (state_q == BUSY);
   assign resp     = (state_q == RESP);

   always_comb begin
      st_wdata = WriteData;
      st_wstrb = 4'b1111;
      case (funct3[1:0])
         2'b00: begin
            st_wdata = {4{WriteData[7:0]}};
            st_wstrb = 4'b0001 << ALUResult[1:0];
         end
         2'b01: begin
            st_wdata = {2{WriteData[15:0]}};
            st_wstrb = 4'b0011 << ALUResult[1:0];
         end
         default: begin
            st_wdata = WriteData;
            st_wstrb = 4'b1111;
         end
      endcase
   end

   assign ld_byte = bus_rdata[8*off_q +: 8];
   assign ld_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

   always_comb begin
      ld_data = bus_rdata;
      case (f3_q)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_data = {24'h0, ld_byte};
         3'b101:  ld_data = {16'h0, ld_half};
         default: ld_data = bus_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= 32'h0;
         we_q    <= 1'b0;
         wdata_q <= 32'h0;
         wstrb_q <= 4'h0;
         f3_q    <= 3'h0;
         off_q   <= 2'h0;
         cnt_q   <= '0;
         rdata_q <= 32'h0;
         to_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (launch) begin
                  addr_q  <= {ALUResult[31:2], 2'b00};
                  we_q    <= MemWrite;
                  wdata_q <= st_wdata;
                  wstrb_q <= MemWrite ? st_wstrb : 4'h0;
                  f3_q    <= funct3;
                  off_q   <= ALUResult[1:0];
                  cnt_q   <= '0;
                  to_q    <= 1'b0;
                  state_q <= BUSY;
               end else if (idle_err) begin
                  rdata_q <= 32'h0;
               end
            end
            BUSY: begin
               // An ack in the final allowed cycle wins over the timeout.
               if (bus_ack) begin
                  rdata_q <= we_q ? 32'h0 : ld_data;
                  to_q    <= 1'b0;
                  state_q <= RESP;
               end else if (cnt_q == CNT_LAST) begin
                  rdata_q <= 32'h0;
                  to_q    <= 1'b1;
                  state_q <= RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign stall_mem = launch | busy;
   assign bus_req   = busy;
   assign bus_we    = busy & we_q;
   assign bus_wstrb = busy ? wstrb_q : 4'h0;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;

   assign rd_valid = resp & ~we_q & ~to_q;
   assign err      = idle_err | (resp & to_q);
   assign ReadData = idle_err ? 32'h0 : rdata_q;

   always_comb begin
      err_code = 2'b00;
      if (idle_err) begin
         err_code = f3_legal ? 2'b01 : 2'b11;
      end else if (resp & to_q) begin
         err_code = 2'b10;
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: the driver queues expected bus and retire
// records, independent monitors pop and compare them as the DUT presents them.
module tb_dmem_access_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_valid;
   logic [1:0]  ResultSrc;
   logic        MemWrite;
   logic [2:0]  funct3;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic        stall_mem;
   logic [31:0] ReadData;
   logic        rd_valid;
   logic        err;
   logic [1:0]  err_code;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   dmem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_valid (mem_valid),
      .ResultSrc (ResultSrc),
      .MemWrite  (MemWrite),
      .funct3    (funct3),
      .ALUResult (ALUResult),
      .WriteData (WriteData),
      .stall_mem (stall_mem),
      .ReadData  (ReadData),
      .rd_valid  (rd_valid),
      .err       (err),
      .err_code  (err_code),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_wstrb (bus_wstrb),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } bus_t;

   typedef struct {
      logic [31:0] rdata;
      logic        rdv;
      logic        err;
      logic [1:0]  code;
   } ret_t;

   bus_t bus_q[$];
   ret_t ret_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Retire monitor: an op leaves MEM in the cycle it is present without a stall.
   initial begin
      ret_t r;
      forever begin
         @(negedge clk);
         if (!reset && mem_valid && (MemWrite || ResultSrc == 2'b01) && !stall_mem) begin
            if (ret_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_retire at %0t", $time);
            end else begin
               r = ret_q.pop_front();
               chk("ReadData", ReadData, r.rdata);
               chk("rd_valid", {31'h0, rd_valid}, {31'h0, r.rdv});
               chk("err", {31'h0, err}, {31'h0, r.err});
               chk("err_code", {30'h0, err_code}, {30'h0, r.code});
            end
         end
      end
   end

   // Bus monitor: pops on the first request cycle and checks stability every cycle.
   initial begin
      bus_t cur;
      logic req_prev;
      req_prev = 1'b0;
      cur = '{addr: 32'h0, we: 1'b0, wdata: 32'h0, wstrb: 4'h0};
      forever begin
         @(negedge clk);
         if (bus_req) begin
            if (!req_prev) begin
               if (bus_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_bus_req addr 0x%08h at %0t", bus_addr, $time);
               end else begin
                  cur = bus_q.pop_front();
               end
            end
            chk("bus_addr", bus_addr, cur.addr);
            chk("bus_we", {31'h0, bus_we}, {31'h0, cur.we});
            chk("bus_wstrb", {28'h0, bus_wstrb}, {28'h0, cur.wstrb});
            if (cur.we) chk("bus_wdata", bus_wdata, cur.wdata);
         end
         req_prev = bus_req;
      end
   end

   // Called at posedge+1; returns at posedge+1 of the cycle after retirement.
   task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int ack_at, input logic [31:0] rd,
                         input int exp_stall, input int exp_req,
                         input logic [31:0] exp_rdata, input logic exp_rdv,
                         input logic [1:0] exp_code, input logic [31:0] exp_baddr,
                         input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata);
      int   stall_n = 0;
      int   req_n = 0;
      logic done = 1'b0;
      ret_q.push_back('{rdata: exp_rdata, rdv: exp_rdv, err: (exp_code != 2'b00),
                        code: exp_code});
      if (exp_req > 0) begin
         bus_q.push_back('{addr: exp_baddr, we: st, wdata: exp_wdata, wstrb: exp_wstrb});
      end
      mem_valid = 1'b1;
      MemWrite  = st;
      ResultSrc = st ? 2'b00 : 2'b01;
      funct3    = f3;
      ALUResult = addr;
      WriteData = wd;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus_req) begin
            req_n++;
            if (req_n == ack_at) begin
               bus_ack   = 1'b1;
               bus_rdata = rd;
            end
         end
         if (!stall_mem) begin
            done = 1'b1;
            break;
         end
         stall_n++;
         @(posedge clk);
         #1 bus_ack = 1'b0;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL op_timeout addr 0x%08h never retired", addr);
      end
      chk("stall_cycles", stall_n, exp_stall);
      chk("req_cycles", req_n, exp_req);
      @(posedge clk);
      #1;
      mem_valid = 1'b0;
      MemWrite  = 1'b0;
      ResultSrc = 2'b00;
      bus_ack   = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      mem_valid = 1'b0;
      ResultSrc = 2'b00;
      MemWrite = 1'b0;
      funct3 = 3'b000;
      ALUResult = 32'h0;
      WriteData = 32'h0;
      bus_ack = 1'b0;
      bus_rdata = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", {31'h0, stall_mem}, 32'h0);
      chk("rst_req", {31'h0, bus_req}, 32'h0);
      chk("rst_we", {31'h0, bus_we}, 32'h0);
      chk("rst_wstrb", {28'h0, bus_wstrb}, 32'h0);
      chk("rst_addr", bus_addr, 32'h0);
      chk("rst_wdata", bus_wdata, 32'h0);
      chk("rst_rdata", ReadData, 32'h0);
      chk("rst_flags", {28'h0, rd_valid, err, err_code}, 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Bubble: ctrl bits set but mem_valid low must not start anything.
      MemWrite = 1'b1;
      @(negedge clk);
      chk("bubble_stall", {31'h0, stall_mem}, 32'h0);
      chk("bubble_req", {31'h0, bus_req}, 32'h0);
      @(posedge clk);
      #1 MemWrite = 1'b0;

      //     st  f3      addr          wdata         ack rdata         stl req exp_rd        rdv code   baddr         wstrb    wdata
      run_op(0, 3'b010, 32'h0000_0100, 32'h0,        3, 32'hDEAD_BEEF, 4, 3, 32'hDEAD_BEEF, 1, 2'b00, 32'h0000_0100, 4'b0000, 32'h0);
      run_op(0, 3'b000, 32'h0000_0103, 32'h0,        1, 32'h80FF_0011, 2, 1, 32'hFFFF_FF80, 1, 2'b00, 32'h0000_0100, 4'b0000, 32'h0);
      run_op(0, 3'b100, 32'h0000_0103, 32'h0,        1, 32'h80FF_0011, 2, 1, 32'h0000_0080, 1, 2'b00, 32'h0000_0100, 4'b0000, 32'h0);
      run_op(0, 3'b001, 32'h0000_0102, 32'h0,        1, 32'h80FF_0011, 2, 1, 32'hFFFF_80FF, 1, 2'b00, 32'h0000_0100, 4'b0000, 32'h0);
      run_op(0, 3'b101, 32'h0000_0102, 32'h0,        1, 32'h80FF_0011, 2, 1, 32'h0000_80FF, 1, 2'b00, 32'h0000_0100, 4'b0000, 32'h0);
      run_op(0, 3'b000, 32'h0000_0100, 32'h0,        1, 32'h80FF_0011, 2, 1, 32'h0000_0011, 1, 2'b00, 32'h0000_0100, 4'b0000, 32'h0);
      run_op(1, 3'b000, 32'h0000_0201, 32'h1234_5678, 2, 32'h0,        3, 2, 32'h0,        0, 2'b00, 32'h0000_0200, 4'b0010, 32'h7878_7878);
      run_op(1, 3'b001, 32'h0000_0202, 32'h1234_5678, 1, 32'h0,        2, 1, 32'h0,        0, 2'b00, 32'h0000_0200, 4'b1100, 32'h5678_5678);
      run_op(1, 3'b010, 32'h0000_0204, 32'h1234_5678, 1, 32'h0,        2, 1, 32'h0,        0, 2'b00, 32'h0000_0204, 4'b1111, 32'h1234_5678);
      // Error cases retire in the IDLE cycle without a bus request.
      run_op(0, 3'b010, 32'h0000_0102, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 2'b01, 32'h0,        4'b0000, 32'h0);
      run_op(1, 3'b011, 32'h0000_0200, 32'h1234_5678, 0, 32'h0,       0, 0, 32'h0,        0, 2'b11, 32'h0,        4'b0000, 32'h0);
      run_op(0, 3'b110, 32'h0000_0101, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 2'b11, 32'h0,        4'b0000, 32'h0);
      run_op(0, 3'b001, 32'h0000_0101, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 2'b01, 32'h0,        4'b0000, 32'h0);
      // Timeout after 4 BUSY cycles, then an ack exactly on the last allowed cycle.
      run_op(0, 3'b010, 32'h0000_0300, 32'h0,        0, 32'h0,        5, 4, 32'h0,        0, 2'b10, 32'h0000_0300, 4'b0000, 32'h0);
      run_op(0, 3'b010, 32'h0000_0304, 32'h0,        4, 32'hCAFE_F00D, 5, 4, 32'hCAFE_F00D, 1, 2'b00, 32'h0000_0304, 4'b0000, 32'h0);
      // Back-to-back loads.
      run_op(0, 3'b010, 32'h0000_0400, 32'h0,        2, 32'h1111_1111, 3, 2, 32'h1111_1111, 1, 2'b00, 32'h0000_0400, 4'b0000, 32'h0);
      run_op(0, 3'b010, 32'h0000_0404, 32'h0,        1, 32'h2222_2222, 2, 1, 32'h2222_2222, 1, 2'b00, 32'h0000_0404, 4'b0000, 32'h0);

      // Reset in the second BUSY cycle, late ack afterwards.
      repeat (2) @(posedge clk);
      #1;
      bus_q.push_back('{addr: 32'h0000_0500, we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
      mem_valid = 1'b1;
      ResultSrc = 2'b01;
      funct3    = 3'b010;
      ALUResult = 32'h0000_0500;
      repeat (3) @(negedge clk);
      chk("pre_reset_req", {31'h0, bus_req}, 32'h1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset     = 1'b0;
      mem_valid = 1'b0;
      ResultSrc = 2'b00;
      bus_ack   = 1'b1;
      bus_rdata = 32'h5555_5555;
      @(negedge clk);
      chk("post_reset_req", {31'h0, bus_req}, 32'h0);
      chk("post_reset_stall", {31'h0, stall_mem}, 32'h0);
      chk("post_reset_rdv", {31'h0, rd_valid}, 32'h0);
      @(posedge clk);
      #1 bus_ack = 1'b0;
      @(negedge clk);
      chk("late_ack_req", {31'h0, bus_req}, 32'h0);
      chk("late_ack_flags", {29'h0, rd_valid, err_code}, 32'h0);
      chk("late_ack_rdata", ReadData, 32'h0);
      @(posedge clk);
      #1;
      run_op(0, 3'b010, 32'h0000_0600, 32'h0,        1, 32'h0000_ABCD, 2, 1, 32'h0000_ABCD, 1, 2'b00, 32'h0000_0600, 4'b0000, 32'h0);

      repeat (2) @(posedge clk);
      checks++;
      if (bus_q.size() != 0 || ret_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_expectations bus %0d retire %0d", bus_q.size(), ret_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
